// File: rtl/instr_prefetch_buf_if.sv
// Handshaked instruction-memory read port used by instr_prefetch_buf.
// One request in flight at a time; exactly one mem_rvalid per granted request.
interface instr_prefetch_buf_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/instr_prefetch_buf.sv
// Sequential instruction prefetch FIFO with tag-match hit detection and redirect flush.
// Optional statistics counters are enabled by defining IPF_STATS_EN.
module instr_prefetch_buf #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          PCF,
    input  logic                 fetch_en,
    output logic [31:0]          InstrF,
    output logic                 instr_valid,
    instr_prefetch_buf_if.master mem
`ifdef IPF_STATS_EN
    ,
    output logic [31:0]          hit_cnt,
    output logic [31:0]          redirect_cnt,
    output logic [15:0]          drop_cnt
`endif
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

    logic [29:0] addr_q [DEPTH];
    logic [31:0] data_q [DEPTH];
    logic [AW:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [29:0] nxt_addr_q, nxt_addr_d;
    logic [29:0] iss_addr_q, iss_addr_d;
    state_e      state_q, state_d;

    logic        empty, full, hit, pop, push, drop, redirect, req, inflight_pc;
    logic [29:0] head_addr;
    logic [29:0] pc_word;
    logic        unused_pcf;

    assign pc_word    = PCF[31:2];
    assign unused_pcf = ^PCF[1:0];
    assign head_addr  = addr_q[rd_ptr_q[AW-1:0]];
    assign empty      = (rd_ptr_q == wr_ptr_q);
    assign full       = (rd_ptr_q[AW] != wr_ptr_q[AW]) && (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]);

    // PCF already requested and awaiting data: stall rather than restart.
    assign inflight_pc = (state_q == StWait) && (iss_addr_q == pc_word);

    assign hit      = ~reset & ~empty & (head_addr == pc_word);
    assign pop      = hit & fetch_en;
    assign redirect = ~reset & (empty ? ((pc_word != nxt_addr_q) & ~inflight_pc)
                                      : (head_addr != pc_word));

    assign instr_valid  = hit;
    assign InstrF       = hit ? data_q[rd_ptr_q[AW-1:0]] : NOP;
    assign mem.mem_req  = req;
    assign mem.mem_addr = reset ? RESET_PC : {nxt_addr_q, 2'b00};

    always_comb begin
        state_d    = state_q;
        nxt_addr_d = nxt_addr_q;
        iss_addr_d = iss_addr_q;
        req        = 1'b0;
        push       = 1'b0;
        drop       = 1'b0;
        unique case (state_q)
            StIdle: begin
                req = ~reset & ~redirect & ~(full & ~pop);
                if (req && mem.mem_gnt) begin
                    state_d    = StWait;
                    iss_addr_d = nxt_addr_q;
                    nxt_addr_d = nxt_addr_q + 30'd1;
                end
            end
            StWait: begin
                if (mem.mem_rvalid) begin
                    state_d = StIdle;
                    // A redirect in the same cycle makes this response stale.
                    drop    = redirect;
                    push    = ~redirect & (~full | pop);
                end else if (redirect) begin
                    state_d = StDrop;
                end
            end
            StDrop: begin
                if (mem.mem_rvalid) begin
                    state_d = StIdle;
                    drop    = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (redirect) begin
            nxt_addr_d = pc_word;
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            nxt_addr_q <= RESET_PC[31:2];
            iss_addr_q <= RESET_PC[31:2];
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            nxt_addr_q <= nxt_addr_d;
            iss_addr_q <= iss_addr_d;
        end
    end

    // Entry storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_q[AW-1:0]] <= iss_addr_q;
            data_q[wr_ptr_q[AW-1:0]] <= mem.mem_rdata;
        end
    end

`ifdef IPF_STATS_EN
    logic [31:0] hit_cnt_q, redirect_cnt_q;
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt_q      <= '0;
            redirect_cnt_q <= '0;
            drop_cnt_q     <= '0;
        end else begin
            if (pop && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + 32'd1;
            if (redirect && (redirect_cnt_q != '1)) redirect_cnt_q <= redirect_cnt_q + 32'd1;
            if (drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign hit_cnt      = hit_cnt_q;
    assign redirect_cnt = redirect_cnt_q;
    assign drop_cnt     = drop_cnt_q;
`endif

endmodule

// File: tb/tb_instr_prefetch_buf.sv
// Bench for instr_prefetch_buf: directed core fetch sequences, a variable-latency
// memory model, and a scoreboard monitor that checks every consumed instruction.
module tb_instr_prefetch_buf;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PCF;
    logic        fetch_en;
    logic [31:0] InstrF;
    logic        instr_valid;
`ifdef IPF_STATS_EN
    logic [31:0] hit_cnt, redirect_cnt;
    logic [15:0] drop_cnt;
`endif

    instr_prefetch_buf_if bus ();

    instr_prefetch_buf #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .PCF         (PCF),
        .fetch_en    (fetch_en),
        .InstrF      (InstrF),
        .instr_valid (instr_valid),
        .mem         (bus)
`ifdef IPF_STATS_EN
        ,
        .hit_cnt      (hit_cnt),
        .redirect_cnt (redirect_cnt),
        .drop_cnt     (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q [$];
    int          mem_lat = 1;
    int          n_resp = 0;
    bit          pend = 0;
    int          wait_c = 0;
    logic [31:0] paddr = '0;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Memory model: grant sampled mid-cycle, response after mem_lat cycles.
    initial begin
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_req) begin
                check("one_outstanding", 32'(pend), 32'd0);
                if (bus.mem_gnt) begin
                    pend   = 1'b1;
                    paddr  = bus.mem_addr;
                    wait_c = mem_lat;
                end
            end
            @(posedge clk);
            #1;
            bus.mem_rvalid = 1'b0;
            if (pend) begin
                wait_c--;
                if (wait_c <= 0) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = memfn(paddr);
                    pend           = 1'b0;
                    n_resp++;
                end
            end
        end
    end

    // Scoreboard monitor: every consumed instruction must match the next expectation.
    always @(negedge clk) begin
        if (!reset && instr_valid && fetch_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got instr %h for pc %h, required no fetch", InstrF, PCF);
            end else begin
                check("sb_instr", InstrF, exp_q.pop_front());
            end
        end
    end

    // Called at posedge+1; consumes n sequential words starting at start.
    task automatic fetch_seq(input logic [31:0] start, input int n,
                             output int first_lat, output int total);
        logic [31:0] pc;
        int          cyc;
        bit          fired;
        pc        = start;
        cyc       = 0;
        first_lat = 0;
        total     = 0;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(memfn(pc));
            PCF      = pc;
            fetch_en = 1'b1;
            fired    = 1'b0;
            for (int k = 0; k < 50 && !fired; k++) begin
                @(negedge clk);
                cyc++;
                fired = instr_valid;
                @(posedge clk);
                #1;
            end
            if (!fired) begin
                checks++;
                errors++;
                $display("FAIL fetch_timeout: pc %h got no instr_valid, required one within 50 cycles", pc);
                exp_q.delete();
                fetch_en = 1'b0;
                return;
            end
            if (i == 0) first_lat = cyc;
            pc = pc + 32'd4;
        end
        total    = cyc;
        fetch_en = 1'b0;
    endtask

    task automatic prime(input logic [31:0] pc);
        PCF      = pc;
        fetch_en = 1'b0;
        repeat (14) @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output bit found);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            found = bus.mem_req;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL wait_req: mem_req never asserted, required within 30 cycles");
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          l, t, k0;
        bit          found;
`ifdef IPF_STATS_EN
        logic [15:0] d0;
`endif
        reset       = 1'b1;
        PCF         = '0;
        fetch_en    = 1'b0;
        bus.mem_gnt = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr_nop", InstrF, 32'h0000_0013);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Cold start from RESET_PC, then sequential fetch with 1-cycle memory.
        fetch_seq(32'h0, 4, l, t);
        check("cold_first_latency", 32'(l), 32'd3);
        check("cold_total_cycles", 32'(t), 32'd9);
`ifdef IPF_STATS_EN
        check("stats_hit_cnt", hit_cnt, 32'd4);
`endif

        // Hold: buffer fills with 0..C, no further requests, stable head.
        prime(32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_instr_valid", 32'(instr_valid), 32'd1);
            check("hold_instr", InstrF, memfn(32'h0));
            check("hold_no_req", 32'(bus.mem_req), 32'd0);
        end
        @(posedge clk);
        #1;

        // Primed buffer streams one word per cycle.
        fetch_seq(32'h0, 4, l, t);
        check("stream_first_latency", 32'(l), 32'd1);
        check("stream_total_cycles", 32'(t), 32'd4);

        // Redirect to 0x100 while the 0x10 request is outstanding.
        prime(32'h0);
        mem_lat = 6;
        fetch_seq(32'h0, 2, l, t);
        check("pre_redirect_total", 32'(t), 32'd2);
        PCF = 32'h8;
        @(posedge clk);
        #1;
        PCF = 32'h100;
        @(negedge clk);
        check("redirect_cycle_invalid", 32'(instr_valid), 32'd0);
        k0 = n_resp;
`ifdef IPF_STATS_EN
        d0 = drop_cnt;
`endif
        @(posedge clk);
        #1;
        mem_lat = 1;
        wait_req(found);
        if (found) begin
            check("stale_resp_before_req", 32'(n_resp), 32'(k0 + 1));
            check("redirect_req_addr", bus.mem_addr, 32'h100);
`ifdef IPF_STATS_EN
            check("stats_drop_cnt", 32'(drop_cnt), 32'(d0) + 32'd1);
`endif
        end
        @(posedge clk);
        #1;
        fetch_seq(32'h100, 2, l, t);
        check("redirect_fill_latency", 32'(l), 32'd2);
        check("redirect_fill_total", 32'(t), 32'd4);

        // Grant withheld: request must hold steady.
        bus.mem_gnt = 1'b0;
        PCF         = 32'h200;
        wait_req(found);
        if (found) begin
            for (int i = 0; i < 5; i++) begin
                if (i > 0) @(negedge clk);
                check("nognt_req", 32'(bus.mem_req), 32'd1);
                check("nognt_addr", bus.mem_addr, 32'h200);
                check("nognt_invalid", 32'(instr_valid), 32'd0);
            end
        end
        @(posedge clk);
        #1;
        bus.mem_gnt = 1'b1;
        fetch_seq(32'h200, 3, l, t);
        check("gnt_release_latency", 32'(l), 32'd3);
        check("gnt_release_total", 32'(t), 32'd7);

        // Address wrap past 0xFFFF_FFFC.
        prime(32'h208);
        fetch_seq(32'hFFFF_FFF8, 4, l, t);
        check("wrap_redirect_latency", 32'(l), 32'd4);
        check("wrap_total_cycles", 32'(t), 32'd10);

        // Reset while a request is outstanding; stray response follows reset.
        mem_lat = 2;
        PCF     = 32'h300;
        found   = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            found = bus.mem_req & bus.mem_gnt;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL wait_gnt_300: no grant seen, required within 30 cycles");
        end
        @(posedge clk);
        #1;
        mem_lat = 1;
        reset   = 1'b1;
        PCF     = 32'h0;
        @(negedge clk);
        check("rst2_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst2_mem_addr", bus.mem_addr, 32'h0);
        check("rst2_instr_valid", 32'(instr_valid), 32'd0);
        check("rst2_instr_nop", InstrF, 32'h0000_0013);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_req", 32'(bus.mem_req), 32'd1);
        check("post_rst_addr", bus.mem_addr, 32'h0);
        check("post_rst_invalid", 32'(instr_valid), 32'd0);
        @(posedge clk);
        #1;
        fetch_seq(32'h0, 2, l, t);
        check("post_rst_latency", 32'(l), 32'd2);
        check("post_rst_total", 32'(t), 32'd4);

        repeat (2) @(posedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
